// File: rtl/sseg_spi_rx_if.sv
// Display-link bundle: serial lines from the driver plus the reassembled register image.
interface sseg_spi_rx_if;
   logic        sclk;
   logic        load;
   logic        sdi;
   logic [63:0] seg;
   logic [7:0]  decode_mode;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic        shutdown;
   logic        disp_test;
   logic        frame_valid;
   logic        frame_err;

   modport slave (
      input  sclk, load, sdi,
      output seg, decode_mode, intensity, scan_limit, shutdown, disp_test,
      output frame_valid, frame_err
   );

   modport master (
      output sclk, load, sdi,
      input  seg, decode_mode, intensity, scan_limit, shutdown, disp_test,
      input  frame_valid, frame_err
   );
endinterface

// File: rtl/sseg_spi_rx.sv
// Seven-segment serial link receiver: 3-cycle sync+edge latency, no backpressure (sampling only).
// Define SSEG_RX_DECODE_EN to apply Code-B font on digits selected by decode_mode.
module sseg_spi_rx (
   input  logic            i_clk,
   input  logic            i_rst_n,
   sseg_spi_rx_if.slave    io_bus
);
   logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic        r_load_s1, r_load_s2, r_load_d;
   logic        r_sdi_s1, r_sdi_s2;
   logic [15:0] r_sr;
   logic [4:0]  r_bc;
   logic [7:0]  r_dig [8];
   logic [7:0]  r_decode_mode;
   logic [3:0]  r_intensity;
   logic [2:0]  r_scan_limit;
   logic        r_shutdown;
   logic        r_disp_test;
   logic        r_frame_valid;
   logic        r_frame_err;

   logic        w_sclk_rise, w_load_rise, w_shift, w_accept;
   logic [15:0] w_sr_nxt;
   logic [4:0]  w_bc_nxt;
   logic [3:0]  w_addr;
   logic [7:0]  w_data;
   logic [2:0]  w_dig_idx;
   logic [63:0] w_seg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_d <= 1'b0;
         r_load_s1 <= 1'b0; r_load_s2 <= 1'b0; r_load_d <= 1'b0;
         r_sdi_s1  <= 1'b0; r_sdi_s2  <= 1'b0;
      end else begin
         r_sclk_s1 <= io_bus.sclk; r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
         r_load_s1 <= io_bus.load; r_load_s2 <= r_load_s1; r_load_d <= r_load_s2;
         r_sdi_s1  <= io_bus.sdi;  r_sdi_s2  <= r_sdi_s1;
      end
   end

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
   assign w_load_rise = r_load_s2 & ~r_load_d;
   // A clock edge coincident with the load rise still counts toward this frame.
   assign w_shift     = w_sclk_rise & (~r_load_s2 | w_load_rise);
   assign w_sr_nxt    = w_shift ? {r_sr[14:0], r_sdi_s2} : r_sr;
   assign w_bc_nxt    = (w_shift && r_bc != 5'd31) ? r_bc + 5'd1 : r_bc;
   assign w_accept    = w_load_rise && (w_bc_nxt == 5'd16);
   assign w_addr      = w_sr_nxt[11:8];
   assign w_data      = w_sr_nxt[7:0];
   assign w_dig_idx   = 3'(w_addr - 4'd1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr          <= '0;
         r_bc          <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_decode_mode <= '0;
         r_intensity   <= '0;
         r_scan_limit  <= '0;
         r_shutdown    <= 1'b1;
         r_disp_test   <= 1'b0;
         for (int i = 0; i < 8; i++) r_dig[i] <= '0;
      end else begin
         r_sr          <= w_sr_nxt;
         r_bc          <= w_load_rise ? 5'd0 : w_bc_nxt;
         r_frame_valid <= w_accept;
         r_frame_err   <= w_load_rise & ~w_accept;
         if (w_accept) begin
            case (w_addr)
               4'h1, 4'h2, 4'h3, 4'h4,
               4'h5, 4'h6, 4'h7, 4'h8: r_dig[w_dig_idx] <= w_data;
               4'h9:    r_decode_mode <= w_data;
               4'hA:    r_intensity   <= w_data[3:0];
               4'hB:    r_scan_limit  <= w_data[2:0];
               4'hC:    r_shutdown    <= ~w_data[0];
               4'hF:    r_disp_test   <= w_data[0];
               default: ;
            endcase
         end
      end
   end

`ifdef SSEG_RX_DECODE_EN
   function automatic logic [6:0] f_codeb(input logic [3:0] i_val);
      case (i_val)
         4'h0: f_codeb = 7'h7E;  4'h1: f_codeb = 7'h30;
         4'h2: f_codeb = 7'h6D;  4'h3: f_codeb = 7'h79;
         4'h4: f_codeb = 7'h33;  4'h5: f_codeb = 7'h5B;
         4'h6: f_codeb = 7'h5F;  4'h7: f_codeb = 7'h70;
         4'h8: f_codeb = 7'h7F;  4'h9: f_codeb = 7'h7B;
         4'hA: f_codeb = 7'h01;  4'hB: f_codeb = 7'h4F;
         4'hC: f_codeb = 7'h37;  4'hD: f_codeb = 7'h0E;
         4'hE: f_codeb = 7'h67;  default: f_codeb = 7'h00;
      endcase
   endfunction
`endif

   always_comb begin
      w_seg = '0;
      for (int n = 0; n < 8; n++) begin
`ifdef SSEG_RX_DECODE_EN
         if (r_decode_mode[n]) w_seg[8*n +: 8] = {r_dig[n][7], f_codeb(r_dig[n][3:0])};
         else                  w_seg[8*n +: 8] = r_dig[n];
`else
         w_seg[8*n +: 8] = r_dig[n];
`endif
         if (r_disp_test) w_seg[8*n +: 8] = 8'hFF;
      end
   end

   assign io_bus.seg         = w_seg;
   assign io_bus.decode_mode = r_decode_mode;
   assign io_bus.intensity   = r_intensity;
   assign io_bus.scan_limit  = r_scan_limit;
   assign io_bus.shutdown    = r_shutdown;
   assign io_bus.disp_test   = r_disp_test;
   assign io_bus.frame_valid = r_frame_valid;
   assign io_bus.frame_err   = r_frame_err;
endmodule
